// File: rtl/exc_commit_ctrl_pkg.sv
// Shared ExcCode values, FSM encodings and BadVAddr source selects for the
// exception commit controller.
package exc_commit_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COMMIT   = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [1:0] BV_NONE   = 2'd0;
  localparam logic [1:0] BV_PC     = 2'd1;
  localparam logic [1:0] BV_DVADDR = 2'd2;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder: picks the winning event.
// Optional trap input enabled by EXC_COMMIT_TRAP_EN.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic       int_sig,
  input  logic       if_adel,
  input  logic       ri,
  input  logic       ov,
  input  logic       sys,
  input  logic       bp,
`ifdef EXC_COMMIT_TRAP_EN
  input  logic       tr,
`endif
  input  logic       adel,
  input  logic       ades,
  input  logic       eret,
  output logic       exc_vld,
  output logic       eret_vld,
  output logic [4:0] code,
  output logic [1:0] bv_sel
);

  always_comb begin
    exc_vld  = 1'b1;
    eret_vld = 1'b0;
    code     = EXC_INT;
    bv_sel   = BV_NONE;
    if (int_sig) begin
      code = EXC_INT;
    end else if (if_adel) begin
      code   = EXC_ADEL;
      bv_sel = BV_PC;
    end else if (ri) begin
      code = EXC_RI;
    end else if (ov) begin
      code = EXC_OV;
    end else if (sys) begin
      code = EXC_SYS;
    end else if (bp) begin
      code = EXC_BP;
`ifdef EXC_COMMIT_TRAP_EN
    end else if (tr) begin
      code = EXC_TR;
`endif
    end else if (adel) begin
      code   = EXC_ADEL;
      bv_sel = BV_DVADDR;
    end else if (ades) begin
      code   = EXC_ADES;
      bv_sel = BV_DVADDR;
    end else begin
      // ERET only commits as ERET when nothing else is pending.
      exc_vld  = 1'b0;
      eret_vld = eret;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ERET commit controller feeding the CP0 commit bus and fetch redirect.
// Optional conditional-trap input enabled by EXC_COMMIT_TRAP_EN.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC_BOOT = 32'hBFC00380,
  parameter logic [31:0] EXC_VEC_NORM = 32'h80000180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic        in_bd,
  input  logic        in_eret,
  input  logic        in_exc_if_adel,
  input  logic        in_exc_ri,
  input  logic        in_exc_ov,
  input  logic        in_exc_sys,
  input  logic        in_exc_bp,
`ifdef EXC_COMMIT_TRAP_EN
  input  logic        in_exc_tr,
`endif
  input  logic        in_exc_adel,
  input  logic        in_exc_ades,
  input  logic [31:0] in_dvaddr,
  input  logic        int_sig,
  input  logic        status_bev,
  input  logic [31:0] cp0_epc,
  output logic        commit_exc,
  output logic        commit_eret,
  output logic [4:0]  commit_code,
  output logic        commit_bd,
  output logic [31:0] commit_epc,
  output logic [31:0] commit_bvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  logic [1:0]  state;
  logic        exc_vld_p0;
  logic        eret_vld_p0;
  logic [4:0]  code_p0;
  logic [1:0]  bv_sel_p0;
  logic [31:0] bva_p0;
  logic        take_p0;

  logic        eret_p1;
  logic [4:0]  code_p1;
  logic        bd_p1;
  logic [31:0] epc_p1;
  logic [31:0] bva_p1;
  logic [31:0] redir_pc_p2;

  // Stage p0: decode the committing instruction's events.
  exc_prio_enc u_prio (
    .int_sig  (int_sig),
    .if_adel  (in_exc_if_adel),
    .ri       (in_exc_ri),
    .ov       (in_exc_ov),
    .sys      (in_exc_sys),
    .bp       (in_exc_bp),
`ifdef EXC_COMMIT_TRAP_EN
    .tr       (in_exc_tr),
`endif
    .adel     (in_exc_adel),
    .ades     (in_exc_ades),
    .eret     (in_eret),
    .exc_vld  (exc_vld_p0),
    .eret_vld (eret_vld_p0),
    .code     (code_p0),
    .bv_sel   (bv_sel_p0)
  );

  always_comb begin
    bva_p0 = 32'd0;
    case (bv_sel_p0)
      BV_PC:     bva_p0 = in_pc;
      BV_DVADDR: bva_p0 = in_dvaddr;
      default:   bva_p0 = 32'd0;
    endcase
  end

  assign in_ready = (state == ST_IDLE);
  assign take_p0  = in_valid & in_ready & (exc_vld_p0 | eret_vld_p0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (take_p0) state <= ST_COMMIT;
        ST_COMMIT:   state <= ST_REDIRECT;
        ST_REDIRECT: if (redirect_ready) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: commit fields captured on the event transfer.
  always_ff @(posedge clk) begin
    if (take_p0) begin
      eret_p1 <= eret_vld_p0;
      code_p1 <= code_p0;
      bd_p1   <= in_bd;
      epc_p1  <= epc_of(in_pc, in_bd);
      bva_p1  <= bva_p0;
    end
  end

  // Stage p2: redirect target sampled from CP0 during the commit cycle.
  always_ff @(posedge clk) begin
    if (state == ST_COMMIT) begin
      redir_pc_p2 <= eret_p1 ? cp0_epc : (status_bev ? EXC_VEC_BOOT : EXC_VEC_NORM);
    end
  end

  assign commit_exc     = (state == ST_COMMIT);
  assign commit_eret    = commit_exc & eret_p1;
  assign commit_code    = commit_exc ? code_p1 : 5'd0;
  assign commit_bd      = commit_exc & bd_p1;
  assign commit_epc     = commit_exc ? epc_p1 : 32'd0;
  assign commit_bvaddr  = commit_exc ? bva_p1 : 32'd0;
  assign flush          = (state != ST_IDLE);
  assign redirect_valid = (state == ST_REDIRECT);
  assign redirect_pc    = redirect_valid ? redir_pc_p2 : 32'd0;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: randomized commits against a priority-table model.
module tb_exc_commit_ctrl;

  localparam logic [31:0] VEC_BOOT = 32'hBFC00380;
  localparam logic [31:0] VEC_NORM = 32'h80000180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic        in_bd = 1'b0;
  logic        in_eret = 1'b0;
  logic        in_exc_if_adel = 1'b0;
  logic        in_exc_ri = 1'b0;
  logic        in_exc_ov = 1'b0;
  logic        in_exc_sys = 1'b0;
  logic        in_exc_bp = 1'b0;
`ifdef EXC_COMMIT_TRAP_EN
  logic        in_exc_tr = 1'b0;
`endif
  logic        in_exc_adel = 1'b0;
  logic        in_exc_ades = 1'b0;
  logic [31:0] in_dvaddr = '0;
  logic        int_sig = 1'b0;
  logic        status_bev = 1'b0;
  logic [31:0] cp0_epc = '0;
  logic        commit_exc;
  logic        commit_eret;
  logic [4:0]  commit_code;
  logic        commit_bd;
  logic [31:0] commit_epc;
  logic [31:0] commit_bvaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;

  exc_commit_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_bd          (in_bd),
    .in_eret        (in_eret),
    .in_exc_if_adel (in_exc_if_adel),
    .in_exc_ri      (in_exc_ri),
    .in_exc_ov      (in_exc_ov),
    .in_exc_sys     (in_exc_sys),
    .in_exc_bp      (in_exc_bp),
`ifdef EXC_COMMIT_TRAP_EN
    .in_exc_tr      (in_exc_tr),
`endif
    .in_exc_adel    (in_exc_adel),
    .in_exc_ades    (in_exc_ades),
    .in_dvaddr      (in_dvaddr),
    .int_sig        (int_sig),
    .status_bev     (status_bev),
    .cp0_epc        (cp0_epc),
    .commit_exc     (commit_exc),
    .commit_eret    (commit_eret),
    .commit_code    (commit_code),
    .commit_bd      (commit_bd),
    .commit_epc     (commit_epc),
    .commit_bvaddr  (commit_bvaddr),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic        eret;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic [31:0] bva;
  } cexp_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } rexp_t;

  cexp_t cq[$];
  rexp_t rq[$];
  logic  rv_prev = 1'b0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Flag bit order: 0 if_adel, 1 ri, 2 ov, 3 sys, 4 bp, 5 tr, 6 adel, 7 ades.
  // Reference: walk the priority table, first raised event wins.
  function automatic void model(input logic int_s, input logic eret, input logic [7:0] fl,
                                input logic [31:0] pc, input logic [31:0] dva,
                                output logic evt, output logic is_eret,
                                output logic [4:0] code, output logic [31:0] bva);
    int          tcode[9] = '{0, 4, 10, 12, 8, 9, 13, 4, 5};
    int          tsrc[9]  = '{0, 1, 0, 0, 0, 0, 0, 2, 2};
    logic [8:0]  ev;
    logic [7:0]  f;
    f = fl;
`ifndef EXC_COMMIT_TRAP_EN
    f[5] = 1'b0;
`endif
    ev = {f, int_s};
    evt = 1'b0; is_eret = 1'b0; code = 5'd0; bva = 32'd0;
    for (int i = 0; i < 9; i++) begin
      if (ev[i] && !evt) begin
        evt  = 1'b1;
        code = 5'(tcode[i]);
        bva  = (tsrc[i] == 1) ? pc : (tsrc[i] == 2) ? dva : 32'd0;
      end
    end
    if (!evt && eret) begin
      evt = 1'b1;
      is_eret = 1'b1;
    end
  endfunction

  task automatic drive_flags(input logic int_s, input logic eret, input logic [7:0] fl);
    int_sig        = int_s;
    in_eret        = eret;
    in_exc_if_adel = fl[0];
    in_exc_ri      = fl[1];
    in_exc_ov      = fl[2];
    in_exc_sys     = fl[3];
    in_exc_bp      = fl[4];
`ifdef EXC_COMMIT_TRAP_EN
    in_exc_tr      = fl[5];
`endif
    in_exc_adel    = fl[6];
    in_exc_ades    = fl[7];
  endtask

  task automatic issue(input logic v, input logic int_s, input logic eret, input logic bd,
                       input logic [7:0] fl, input logic [31:0] pc, input logic [31:0] dva,
                       input logic bev_c, input logic [31:0] epc_c, input int d,
                       input bit rst_in_commit);
    logic        evt, iser;
    logic [4:0]  code;
    logic [31:0] bva;
    cexp_t       ce;
    rexp_t       re;
    model(int_s, eret, fl, pc, dva, evt, iser, code, bva);
    in_valid = v; in_pc = pc; in_bd = bd; in_dvaddr = dva;
    drive_flags(int_s, eret, fl);
    chk1("ready_in_idle", in_ready, 1'b1);
    if (v && evt) begin
      ce.cyc = cyc + 1; ce.eret = iser; ce.code = code; ce.bd = bd;
      ce.epc = bd ? pc - 32'd4 : pc; ce.bva = bva;
      cq.push_back(ce);
      re.cyc = cyc + 2;
      re.pc  = iser ? epc_c : (bev_c ? VEC_BOOT : VEC_NORM);
      rq.push_back(re);
    end
    @(posedge clk) #1;
    if (!(v && evt)) begin
      in_valid = 1'b0;
      drive_flags(1'b0, 1'b0, 8'h00);
      chk1("retire_ready", in_ready, 1'b1);
      chk1("retire_no_flush", flush, 1'b0);
      return;
    end
    // Commit cycle: CP0 inputs take their commit-time values; upstream junk is held.
    cp0_epc = epc_c; status_bev = bev_c;
    in_valid = 1'b1; in_pc = $urandom;
    drive_flags(1'($urandom), 1'($urandom), 8'($urandom));
    if (rst_in_commit) begin
      reset = 1'b1;
      #1;
      chk1("rst_commit_exc", commit_exc, 1'b0);
      chk1("rst_commit_eret", commit_eret, 1'b0);
      chk32("rst_commit_code", 32'(commit_code), 32'd0);
      chk1("rst_flush", flush, 1'b0);
      chk1("rst_redirect_valid", redirect_valid, 1'b0);
      chk32("rst_redirect_pc", redirect_pc, 32'd0);
      chk1("rst_in_ready", in_ready, 1'b1);
      cq.delete(); rq.delete();
      in_valid = 1'b0;
      drive_flags(1'b0, 1'b0, 8'h00);
      @(posedge clk) #1;
      reset = 1'b0;
      return;
    end
    redirect_ready = 1'($urandom);
    @(posedge clk) #1;
    cp0_epc = $urandom; status_bev = 1'($urandom);
    for (int i = 0; i < d; i++) begin
      redirect_ready = 1'b0;
      @(posedge clk) #1;
    end
    redirect_ready = 1'b1;
    in_valid = 1'b0;
    drive_flags(1'b0, 1'b0, 8'h00);
    @(posedge clk) #1;
    redirect_ready = 1'b0;
    chk1("back_idle_ready", in_ready, 1'b1);
    chk1("back_idle_flush", flush, 1'b0);
    chk1("back_idle_rv", redirect_valid, 1'b0);
  endtask

  // Monitor: compares every DUT presentation against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (commit_exc) begin
        if (cq.size() == 0) begin
          chk1("unexpected_commit", commit_exc, 1'b0);
        end else begin
          cexp_t e;
          e = cq.pop_front();
          chk32("commit_latency", 32'(cyc), 32'(e.cyc));
          chk1("commit_eret", commit_eret, e.eret);
          chk32("commit_code", 32'(commit_code), 32'(e.code));
          chk1("commit_bd", commit_bd, e.bd);
          chk32("commit_epc", commit_epc, e.epc);
          chk32("commit_bvaddr", commit_bvaddr, e.bva);
          chk1("commit_flush", flush, 1'b1);
          chk1("commit_in_ready", in_ready, 1'b0);
          chk1("commit_rv", redirect_valid, 1'b0);
        end
      end else begin
        chk32("idle_commit_fields", {commit_eret, commit_bd, commit_code, 25'd0} | commit_epc | commit_bvaddr, 32'd0);
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          chk1("unexpected_redirect", redirect_valid, 1'b0);
        end else begin
          if (!rv_prev) chk32("redirect_latency", 32'(cyc), 32'(rq[0].cyc));
          chk32("redirect_pc", redirect_pc, rq[0].pc);
          chk1("redirect_flush", flush, 1'b1);
          chk1("redirect_in_ready", in_ready, 1'b0);
          if (redirect_ready) void'(rq.pop_front());
        end
      end
      rv_prev = redirect_valid;
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    #3;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_commit_exc", commit_exc, 1'b0);
    chk1("reset_flush", flush, 1'b0);
    chk1("reset_redirect_valid", redirect_valid, 1'b0);
    chk32("reset_redirect_pc", redirect_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(1, 0, 0, 0, 8'h04, 32'h80001000, 32'h0, 0, 32'h0, 1, 0);
    issue(1, 0, 0, 1, 8'h40, 32'h80001004, 32'h80002003, 0, 32'h0, 0, 0);
    issue(1, 1, 0, 0, 8'h02, 32'h80003000, 32'h0, 1, 32'h0, 0, 0);
    issue(1, 0, 1, 0, 8'h00, 32'h80004000, 32'h0, 0, 32'hBFC00700, 0, 0);
    issue(1, 0, 1, 0, 8'h01, 32'h80005002, 32'h0, 0, 32'hBFC00700, 1, 0);
    issue(1, 0, 0, 0, 8'h08, 32'h80006000, 32'h0, 1, 32'h0, 5, 0);
    issue(1, 0, 0, 0, 8'h00, 32'h80006004, 32'h0, 0, 32'h0, 0, 0);
    issue(1, 0, 0, 0, 8'h10, 32'h80007000, 32'h0, 0, 32'h0, 0, 1);
    issue(1, 0, 0, 1, 8'h80, 32'h80008000, 32'h8000FFF1, 0, 32'h0, 2, 0);
    issue(1, 0, 0, 0, 8'h20, 32'h80009000, 32'h0, 0, 32'h0, 0, 0);
    issue(1, 0, 0, 1, 8'h00, 32'h00000000, 32'h0, 0, 32'h0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic       v, is, er;
      logic [7:0] fl;
      v  = ($urandom % 8) != 0;
      is = v ? (($urandom % 8) == 0) : 1'b1;
      er = ($urandom % 6) == 0;
      for (int b = 0; b < 8; b++) fl[b] = v ? (($urandom % 10) == 0) : 1'($urandom);
      issue(v, is, er, 1'($urandom), fl, $urandom, $urandom, 1'($urandom), $urandom,
            int'($urandom % 4), ($urandom % 25) == 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk32("commit_queue_drained", 32'(cq.size()), 32'd0);
    chk32("redirect_queue_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
